// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: state encoding, frame size, default bit period.
package uart_pkg;

    typedef enum logic [2:0] {
        WAIT_IDLE = 3'd0,
        IDLE      = 3'd1,
        START     = 3'd2,
        DATA      = 3'd3,
        STOP      = 3'd4
    } rx_state_t;

    localparam int DATA_BITS            = 8;
    localparam int CLKS_PER_BIT_DEFAULT = 104;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchronizer for an idle-high async line; both flops reset to 1.
module rx_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_sync
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
        end
    end

    assign o_sync = r_sync;

endmodule

// File: rtl/uart_rx_bitstream.sv
// 8N1 receiver that emits each data bit as a one-cycle strobe, LSB first, marking bit 0 of each byte.
// Optional macro UART_RX_MAJORITY_VOTE_EN: 2-of-3 vote around mid-bit, decisions one cycle later.
//
// state     | meaning
// WAIT_IDLE | wait for CLKS_PER_BIT consecutive high samples before arming
// IDLE      | armed, waiting for a high->low edge
// START     | timing to mid start bit; high sample rejects the edge as a glitch
// DATA      | sample and strobe 8 data bits at mid-bit
// STOP      | check stop bit; low flags a framing error and re-enters WAIT_IDLE
module uart_rx_bitstream
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_pin,
    output logic rx_bit,
    output logic rx_bit_valid_now,
    output logic rx_byte_start,
    output logic rx_frame_err,
    output logic rx_busy
);

    localparam int HALF_BIT = CLKS_PER_BIT / 2;
    localparam int CNT_W    = $clog2(CLKS_PER_BIT);
    localparam int IDX_W    = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF_BIT);
`else
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(HALF_BIT - 1);
`endif

    logic w_sync;
    logic w_sample;

    rx_state_t        r_state;
    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [IDX_W-1:0] r_bit_idx;
    logic [IDX_W-1:0] w_idx_nxt;
    logic             r_prev;
    logic             w_strobe;
    logic             w_err;
    logic             w_bit_nxt;

    logic r_bit;
    logic r_valid;
    logic r_byte_start;
    logic r_err;
    logic r_busy;

    rx_sync u_sync (
        .clk     (clk),
        .rst     (rst),
        .i_async (rx_pin),
        .o_sync  (w_sync)
    );

`ifdef UART_RX_MAJORITY_VOTE_EN
    // r_hist[1] is mid-1 and r_hist[0] is mid when the decision is taken at mid+1
    logic [1:0] r_hist;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_sync};
        end
    end

    assign w_sample = (r_hist[1] & r_hist[0]) | (r_hist[1] & w_sync) | (r_hist[0] & w_sync);
`else
    assign w_sample = w_sync;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_bit_idx;
        w_strobe    = 1'b0;
        w_err       = 1'b0;
        w_bit_nxt   = r_bit;
        case (r_state)
            WAIT_IDLE: begin
                if (!w_sync) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            IDLE: begin
                w_cnt_nxt = '0;
                if (r_prev && !w_sync) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                if (r_cnt == START_LAST) begin
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = '0;
                    w_state_nxt = w_sample ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    w_strobe  = 1'b1;
                    w_bit_nxt = w_sample;
                    if (r_bit_idx == IDX_LAST) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_idx_nxt = r_bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                if (r_cnt == CNT_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_sample) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = WAIT_IDLE;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = WAIT_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= WAIT_IDLE;
            r_cnt        <= '0;
            r_bit_idx    <= '0;
            r_prev       <= 1'b1;
            r_bit        <= 1'b0;
            r_valid      <= 1'b0;
            r_byte_start <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_bit_idx    <= w_idx_nxt;
            r_prev       <= w_sync;
            r_bit        <= w_bit_nxt;
            r_valid      <= w_strobe;
            r_byte_start <= w_strobe && (r_bit_idx == '0);
            r_err        <= w_err;
            r_busy       <= (w_state_nxt == START) || (w_state_nxt == DATA) ||
                            (w_state_nxt == STOP);
        end
    end

    assign rx_bit           = r_bit;
    assign rx_bit_valid_now = r_valid;
    assign rx_byte_start    = r_byte_start;
    assign rx_frame_err     = r_err;
    assign rx_busy          = r_busy;

endmodule

// File: tb/tb_uart_rx_bitstream.sv
// Scoreboard bench for uart_rx_bitstream: two instances (16 and 104 clocks per bit).
module tb_uart_rx_bitstream;

`ifdef UART_RX_MAJORITY_VOTE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif
    localparam int CPB_A = 16;
    localparam int CPB_B = 104;
    localparam int LIMIT = 30000;

    typedef struct {
        int   cyc;
        logic b;
        logic s;
    } exp_t;

    typedef struct {
        int   cyc;
        logic v;
    } busy_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pin_a = 1'b1;
    logic pin_b = 1'b1;
    logic a_bit, a_valid, a_start, a_err, a_busy;
    logic b_bit, b_valid, b_start, b_err, b_busy;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    logic stim_done = 1'b0;

    exp_t  qa[$];
    exp_t  qb[$];
    int    qerr[$];
    busy_t qbusy[$];

    uart_rx_bitstream #(.CLKS_PER_BIT(CPB_A)) dut_a (
        .clk              (clk),
        .rst              (rst),
        .rx_pin           (pin_a),
        .rx_bit           (a_bit),
        .rx_bit_valid_now (a_valid),
        .rx_byte_start    (a_start),
        .rx_frame_err     (a_err),
        .rx_busy          (a_busy)
    );

    uart_rx_bitstream #(.CLKS_PER_BIT(CPB_B)) dut_b (
        .clk              (clk),
        .rst              (rst),
        .rx_pin           (pin_b),
        .rx_bit           (b_bit),
        .rx_bit_valid_now (b_valid),
        .rx_byte_start    (b_start),
        .rx_frame_err     (b_err),
        .rx_busy          (b_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) pin_a = v;
        else pin_b = v;
    endtask

    // Reference: T0 is two cycles after the pin falls; bit n strobes at T0+HALF+(n+1)*CPB+1.
    task automatic send(input int which, input logic [7:0] b, input logic stop_ok,
                        input logic expect_rx, input int spike);
        int   p;
        int   cpb;
        int   half;
        int   t0;
        exp_t e;
        busy_t bz;
        cpb  = (which == 0) ? CPB_A : CPB_B;
        half = cpb / 2;
        p    = cyc;
        t0   = p + 2;
        drive(which, 1'b0);
        if (expect_rx) begin
            for (int n = 0; n < 8; n++) begin
                e.cyc = t0 + half + (n + 1) * cpb + 1 + LAT;
                e.b   = b[n];
                e.s   = (n == 0);
                if (which == 0) qa.push_back(e);
                else qb.push_back(e);
            end
            if (which == 0) begin
                if (!stop_ok) qerr.push_back(t0 + half + 9 * cpb + 1 + LAT);
                bz.cyc = t0 + 1;                      bz.v = 1'b1; qbusy.push_back(bz);
                bz.cyc = t0 + half + 9 * cpb + LAT;     bz.v = 1'b1; qbusy.push_back(bz);
                bz.cyc = t0 + half + 9 * cpb + 1 + LAT; bz.v = 1'b0; qbusy.push_back(bz);
            end
        end
        tick(cpb);
        for (int n = 0; n < 8; n++) begin
            drive(which, b[n]);
            if (n == spike) begin
                tick(half);
                drive(which, ~b[n]);
                tick(1);
                drive(which, b[n]);
                tick(cpb - half - 1);
            end else begin
                tick(cpb);
            end
        end
        drive(which, stop_ok);
        tick(cpb);
        drive(which, 1'b1);
    endtask

    initial begin : stim
        int   p;
        int   gap;
        logic [7:0] rb;
        logic ok;
        exp_t e;
        busy_t bz;
        tick(3);
        rst = 1'b0;
        tick(20);

        send(0, 8'h82, 1'b1, 1'b1, -1);
        send(0, 8'h19, 1'b1, 1'b1, -1);
        tick(10);

        // short low glitch on an idle line
        p = cyc;
        bz.cyc = p + 2;              bz.v = 1'b0; qbusy.push_back(bz);
        bz.cyc = p + 3;              bz.v = 1'b1; qbusy.push_back(bz);
        bz.cyc = p + 10 + LAT;       bz.v = 1'b1; qbusy.push_back(bz);
        bz.cyc = p + 11 + LAT;       bz.v = 1'b0; qbusy.push_back(bz);
        pin_a = 1'b0;
        tick(5);
        pin_a = 1'b1;
        tick(30);

        // framing error, short recovery, ignored frame, then a clean frame
        send(0, 8'h55, 1'b0, 1'b1, -1);
        tick(8);
        send(0, 8'h00, 1'b1, 1'b0, -1);
        tick(30);
        send(0, 8'h55, 1'b1, 1'b1, -1);
        tick(5);

        // randomized frames, some back-to-back, some with a bad stop bit
        for (int k = 0; k < 8; k++) begin
            rb  = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 3) != 0);
            gap = $urandom_range(0, 12);
            send(0, rb, ok, 1'b1, -1);
            tick(ok ? gap : gap + 24);
        end
        tick(20);

        // reset in the middle of 0xFF, right at strobe 4, then line held low
        p = cyc;
        pin_a = 1'b0;
        for (int n = 0; n < 4; n++) begin
            e.cyc = p + 2 + CPB_A / 2 + (n + 1) * CPB_A + 1 + LAT;
            e.b   = 1'b1;
            e.s   = (n == 0);
            qa.push_back(e);
        end
        tick(CPB_A);
        pin_a = 1'b1;
        tick(2 + CPB_A / 2 + 4 * CPB_A + 1 + LAT - CPB_A);
        rst   = 1'b1;
        pin_a = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(40);
        pin_a = 1'b1;
        tick(24);
        send(0, 8'h82, 1'b1, 1'b1, -1);
        tick(20);

        // long bit period instance
        send(1, 8'hA5, 1'b1, 1'b1, -1);
        for (int k = 0; k < 2; k++) begin
            rb = 8'($urandom_range(0, 255));
            send(1, rb, 1'b1, 1'b1, -1);
            tick($urandom_range(0, 30));
        end

`ifdef UART_RX_MAJORITY_VOTE_EN
        tick(10);
        send(0, 8'h82, 1'b1, 1'b1, 1);
`endif
        tick(200);
        stim_done = 1'b1;
    end

    always @(negedge clk) begin : mon
        exp_t  e;
        busy_t bz;
        int    ec;

        if (cyc == 2) begin
            total++;
            if ({a_bit, a_valid, a_start, a_err, a_busy, b_bit, b_valid, b_start, b_err, b_busy} !== 10'b0) begin
                bad++;
                $display("FAIL reset_outputs: got %b required 0000000000",
                         {a_bit, a_valid, a_start, a_err, a_busy, b_bit, b_valid, b_start, b_err, b_busy});
            end
        end

        if (qa.size() > 0 && qa[0].cyc < cyc) begin
            e = qa.pop_front();
            total++; bad++;
            $display("FAIL strobe_a_missing: got none at cyc %0d required strobe", e.cyc);
        end
        if (qb.size() > 0 && qb[0].cyc < cyc) begin
            e = qb.pop_front();
            total++; bad++;
            $display("FAIL strobe_b_missing: got none at cyc %0d required strobe", e.cyc);
        end
        if (qerr.size() > 0 && qerr[0] < cyc) begin
            ec = qerr.pop_front();
            total++; bad++;
            $display("FAIL err_a_missing: got none at cyc %0d required pulse", ec);
        end

        if (a_valid) begin
            if (qa.size() == 0) begin
                total++; bad++;
                $display("FAIL strobe_a_extra: got strobe at cyc %0d required none", cyc);
            end else begin
                e = qa.pop_front();
                total++;
                if (cyc != e.cyc) begin
                    bad++;
                    $display("FAIL strobe_a_time: got cyc %0d required %0d", cyc, e.cyc);
                end
                total++;
                if (a_bit !== e.b) begin
                    bad++;
                    $display("FAIL strobe_a_bit: got %b required %b at cyc %0d", a_bit, e.b, cyc);
                end
                total++;
                if (a_start !== e.s) begin
                    bad++;
                    $display("FAIL byte_start_a: got %b required %b at cyc %0d", a_start, e.s, cyc);
                end
            end
        end else if (a_start) begin
            total++; bad++;
            $display("FAIL byte_start_a_alone: got 1 required 0 at cyc %0d", cyc);
        end

        if (b_valid) begin
            if (qb.size() == 0) begin
                total++; bad++;
                $display("FAIL strobe_b_extra: got strobe at cyc %0d required none", cyc);
            end else begin
                e = qb.pop_front();
                total++;
                if (cyc != e.cyc) begin
                    bad++;
                    $display("FAIL strobe_b_time: got cyc %0d required %0d", cyc, e.cyc);
                end
                total++;
                if (b_bit !== e.b) begin
                    bad++;
                    $display("FAIL strobe_b_bit: got %b required %b at cyc %0d", b_bit, e.b, cyc);
                end
                total++;
                if (b_start !== e.s) begin
                    bad++;
                    $display("FAIL byte_start_b: got %b required %b at cyc %0d", b_start, e.s, cyc);
                end
            end
        end else if (b_start) begin
            total++; bad++;
            $display("FAIL byte_start_b_alone: got 1 required 0 at cyc %0d", cyc);
        end

        if (a_err) begin
            if (qerr.size() == 0) begin
                total++; bad++;
                $display("FAIL err_a_extra: got pulse at cyc %0d required none", cyc);
            end else begin
                ec = qerr.pop_front();
                total++;
                if (cyc != ec) begin
                    bad++;
                    $display("FAIL err_a_time: got cyc %0d required %0d", cyc, ec);
                end
            end
        end
        if (b_err) begin
            total++; bad++;
            $display("FAIL err_b_extra: got pulse at cyc %0d required none", cyc);
        end

        if (qbusy.size() > 0 && qbusy[0].cyc == cyc) begin
            bz = qbusy.pop_front();
            total++;
            if (a_busy !== bz.v) begin
                bad++;
                $display("FAIL busy_a: got %b required %b at cyc %0d", a_busy, bz.v, cyc);
            end
        end

        if (stim_done || cyc > LIMIT) begin
            if (!stim_done) begin
                total++; bad++;
                $display("FAIL timeout: got cyc %0d required finish before %0d", cyc, LIMIT);
            end
            total++;
            if (qa.size() != 0 || qb.size() != 0) begin
                bad++;
                $display("FAIL strobes_left: got %0d/%0d pending required 0/0", qa.size(), qb.size());
            end
            total++;
            if (qerr.size() != 0 || qbusy.size() != 0) begin
                bad++;
                $display("FAIL checks_left: got %0d err %0d busy pending required 0", qerr.size(), qbusy.size());
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

endmodule
